// File: rtl/product_accumulator_if.sv
// rtl/product_accumulator_if.sv - product input stream and frame result stream of the product accumulator
interface product_accumulator_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);
    // product input stream
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_prod;
    logic             in_last;

    // frame result stream
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    // upstream producer / downstream consumer side
    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    // accumulator side
    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - frame MAC accumulator of 16-bit products; PRODUCT_ACC_SATURATE_EN clamps the sum instead of wrapping
module product_accumulator #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    product_accumulator_if.slave    bus
);
    localparam int SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;

    // running frame state
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    // result register, presented on the output stream
    logic [ACC_W-1:0] res_sum;
    logic [CNT_W-1:0] res_cnt;
    logic             res_ovf;
    logic             res_valid;

    logic             in_ready_w;
    logic             accept;
    logic             drain;
    logic [SUM_W-1:0] sum_ext;
    logic             sum_carry;
    logic [ACC_W-1:0] next_acc;
    logic             cnt_full;
    logic [CNT_W-1:0] next_cnt;
    logic             next_ovf;

    // A pending result blocks input unless it drains this same cycle,
    // so in_ready never looks at in_valid.
    assign in_ready_w = (state != HOLD) || bus.out_ready;
    assign accept     = bus.in_valid && in_ready_w;
    assign drain      = (state == HOLD) && bus.out_ready;

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = res_valid;
    assign bus.out_sum   = res_sum;
    assign bus.out_count = res_cnt;
    assign bus.out_ovf   = res_ovf;

    // Next accumulator value with one guard bit to catch the carry out;
    // count saturates at all-ones and flags an overflow instead of wrapping.
    always_comb begin
        sum_ext   = {1'b0, acc} + SUM_W'(bus.in_prod);
        sum_carry = sum_ext[ACC_W];
`ifdef PRODUCT_ACC_SATURATE_EN
        // once clamped, any further non-zero product carries again and re-clamps
        next_acc  = sum_carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
        next_acc  = sum_ext[ACC_W-1:0];
`endif
        cnt_full  = &cnt;
        next_cnt  = cnt_full ? cnt : cnt + CNT_W'(1);
        next_ovf  = ovf | sum_carry | cnt_full;
    end

    // Frame state machine: accumulate, load the result on the last term,
    // hold it until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            res_sum   <= '0;
            res_cnt   <= '0;
            res_ovf   <= 1'b0;
            res_valid <= 1'b0;
        end else if (accept) begin
            // In HOLD, accept implies the old result drains this cycle and acc/cnt/ovf are already clear.
            if (bus.in_last) begin
                res_sum   <= next_acc;
                res_cnt   <= next_cnt;
                res_ovf   <= next_ovf;
                res_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
                ovf       <= 1'b0;
                state     <= HOLD;
            end else begin
                acc       <= next_acc;
                cnt       <= next_cnt;
                ovf       <= next_ovf;
                res_valid <= 1'b0;
                state     <= ACCUM;
            end
        end else if (drain) begin
            res_valid <= 1'b0;
            state     <= IDLE;
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - self-checking bench for product_accumulator across three parameter sets
module tb_product_accumulator;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_prod;
    logic        in_last;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef PRODUCT_ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    always #5 clk = ~clk;

    // instance 0: ACC_W=24 CNT_W=8, instance 1: ACC_W=16 CNT_W=8, instance 2: ACC_W=24 CNT_W=2
    product_accumulator_if #(.ACC_W(24), .CNT_W(8)) b24 ();
    product_accumulator_if #(.ACC_W(16), .CNT_W(8)) b16 ();
    product_accumulator_if #(.ACC_W(24), .CNT_W(2)) bc ();

    product_accumulator #(.ACC_W(24), .CNT_W(8)) u24 (.clk(clk), .rst(rst), .bus(b24));
    product_accumulator #(.ACC_W(16), .CNT_W(8)) u16 (.clk(clk), .rst(rst), .bus(b16));
    product_accumulator #(.ACC_W(24), .CNT_W(2)) uc  (.clk(clk), .rst(rst), .bus(bc));

    assign b24.in_valid = in_valid; assign b24.in_prod = in_prod;
    assign b24.in_last  = in_last;  assign b24.out_ready = out_ready;
    assign b16.in_valid = in_valid; assign b16.in_prod = in_prod;
    assign b16.in_last  = in_last;  assign b16.out_ready = out_ready;
    assign bc.in_valid  = in_valid; assign bc.in_prod  = in_prod;
    assign bc.in_last   = in_last;  assign bc.out_ready  = out_ready;

    logic [31:0] d_sum   [3];
    logic [7:0]  d_cnt   [3];
    logic        d_valid [3];
    logic        d_ready [3];
    logic        d_ovf   [3];

    assign d_sum[0] = 32'(b24.out_sum);  assign d_cnt[0] = 8'(b24.out_count);
    assign d_sum[1] = 32'(b16.out_sum);  assign d_cnt[1] = 8'(b16.out_count);
    assign d_sum[2] = 32'(bc.out_sum);   assign d_cnt[2] = 8'(bc.out_count);
    assign d_valid[0] = b24.out_valid; assign d_ready[0] = b24.in_ready; assign d_ovf[0] = b24.out_ovf;
    assign d_valid[1] = b16.out_valid; assign d_ready[1] = b16.in_ready; assign d_ovf[1] = b16.out_ovf;
    assign d_valid[2] = bc.out_valid;  assign d_ready[2] = bc.in_ready;  assign d_ovf[2] = bc.out_ovf;

    int aw [3] = '{24, 16, 24};
    int cw [3] = '{8, 8, 2};

    // model: exact frame sum and term count, result derived from them on the last term
    longint tsum    [3];
    int     tn      [3];
    bit     pend    [3];
    longint exp_sum [3];
    longint exp_cnt [3];
    bit     exp_ovf [3];
    bit     started = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            tsum[k] = 0; tn[k] = 0; pend[k] = 1'b0;
            exp_sum[k] = 0; exp_cnt[k] = 0; exp_ovf[k] = 1'b0;
        end
        forever begin
            @(posedge clk);
            started = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (rst) begin
                    tsum[k] = 0; tn[k] = 0; pend[k] = 1'b0;
                end else begin
                    longint maxs;
                    longint maxc;
                    bit     take;
                    maxs = (64'd1 << aw[k]) - 1;
                    maxc = (64'd1 << cw[k]) - 1;
                    take = in_valid && (!pend[k] || out_ready);
                    if (pend[k] && out_ready) pend[k] = 1'b0;
                    if (take) begin
                        tsum[k] += longint'(in_prod);
                        tn[k]++;
                        if (in_last) begin
                            exp_ovf[k] = (tsum[k] > maxs) || (longint'(tn[k]) > maxc);
                            if (SAT) exp_sum[k] = (tsum[k] > maxs) ? maxs : tsum[k];
                            else     exp_sum[k] = tsum[k] & maxs;
                            exp_cnt[k] = (longint'(tn[k]) > maxc) ? maxc : longint'(tn[k]);
                            pend[k] = 1'b1;
                            tsum[k] = 0;
                            tn[k] = 0;
                        end
                    end
                end
            end
        end
    end

    // compare every cycle against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("in_ready[%0d]", k), longint'(d_ready[k]), longint'(!pend[k] || out_ready));
                    chk($sformatf("out_valid[%0d]", k), longint'(d_valid[k]), longint'(pend[k]));
                    if (pend[k]) begin
                        chk($sformatf("out_sum[%0d]", k), longint'(d_sum[k]), exp_sum[k]);
                        chk($sformatf("out_count[%0d]", k), longint'(d_cnt[k]), exp_cnt[k]);
                        chk($sformatf("out_ovf[%0d]", k), longint'(d_ovf[k]), longint'(exp_ovf[k]));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] p, input logic l);
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        step();
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_prod  = 16'h0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_prod = 16'h0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();

        // reset then idle
        @(negedge clk);
        chk("rst_valid", longint'(b24.out_valid), 0);
        chk("rst_sum",   longint'(b24.out_sum), 0);
        chk("rst_count", longint'(b24.out_count), 0);
        chk("rst_ovf",   longint'(b24.out_ovf), 0);
        chk("rst_ready", longint'(b24.in_ready), 1);

        // four-term frame
        beat(16'hFE01, 1'b0); beat(16'hFE01, 1'b0); beat(16'hFE01, 1'b0); beat(16'hFE01, 1'b1);
        idle_in();
        @(negedge clk);
        chk("four_valid", longint'(b24.out_valid), 1);
        chk("four_sum",   longint'(b24.out_sum), 'h03F804);
        chk("four_count", longint'(b24.out_count), 4);
        chk("four_ovf",   longint'(b24.out_ovf), 0);
        repeat (2) step();

        // backpressure, then drain together with a new single-term frame
        out_ready = 1'b0;
        beat(16'h0001, 1'b1);
        idle_in();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", longint'(b24.out_valid), 1);
            chk("bp_sum",   longint'(b24.out_sum), 1);
            chk("bp_count", longint'(b24.out_count), 1);
            chk("bp_ready", longint'(b24.in_ready), 0);
        end
        out_ready = 1'b1;
        beat(16'h0010, 1'b1);
        idle_in();
        @(negedge clk);
        chk("reload_valid", longint'(b24.out_valid), 1);
        chk("reload_sum",   longint'(b24.out_sum), 'h10);
        chk("reload_count", longint'(b24.out_count), 1);
        repeat (2) step();

        // sum overflow on the 16-bit instance
        beat(16'hFE01, 1'b0); beat(16'hFE01, 1'b1);
        idle_in();
        @(negedge clk);
        chk("ovf_sum", longint'(b16.out_sum), SAT ? 'hFFFF : 'hFC02);
        chk("ovf_flag", longint'(b16.out_ovf), 1);
        repeat (2) step();

        // count saturation on the CNT_W=2 instance
        for (int i = 0; i < 4; i++) beat(16'h0001, 1'b0);
        beat(16'h0001, 1'b1);
        idle_in();
        @(negedge clk);
        chk("cnt_count", longint'(bc.out_count), 3);
        chk("cnt_sum",   longint'(bc.out_sum), 5);
        chk("cnt_ovf",   longint'(bc.out_ovf), 1);
        repeat (2) step();

        // reset mid-frame discards the partial sum
        beat(16'h0100, 1'b0); beat(16'h0100, 1'b0);
        idle_in();
        rst = 1'b1;
        step();
        rst = 1'b0;
        beat(16'h0002, 1'b1);
        idle_in();
        @(negedge clk);
        chk("midrst_valid", longint'(b24.out_valid), 1);
        chk("midrst_sum",   longint'(b24.out_sum), 2);
        chk("midrst_count", longint'(b24.out_count), 1);
        chk("midrst_ovf",   longint'(b24.out_ovf), 0);

        // reset while holding a result drops it
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("holdrst_valid", longint'(b24.out_valid), 0);
        chk("holdrst_sum",   longint'(b24.out_sum), 0);
        chk("holdrst_ready", longint'(b24.in_ready), 1);
        out_ready = 1'b1;
        step();

        // mixed traffic with toggling backpressure, checked by the model
        for (int i = 0; i < 200; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_prod   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            in_last   = ($urandom_range(0, 4) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        idle_in();
        out_ready = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
